// File: rtl/stopwatch_display_scan.sv
// Four-slot multiplexed 7-segment scanner for the stopwatch readout (tens.ones.tenths).
// Takes one stable snapshot per frame and blanks between digits to avoid ghosting.
module stopwatch_display_scan #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic [3:0] tenths,
    input  logic       hold,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

    logic [11:0]   r_s1;
    logic [11:0]   r_s2;
    logic [11:0]   r_shadow;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_slot;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_frame_start;
    logic          w_gap;
    logic          w_dark;
    logic [3:0]    w_digit;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_frame_start = (r_cnt == '0) && (r_slot == 2'd0);

    // Two-flop resync; the snapshot is only taken when both stages agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_shadow <= '0;
        end else begin
            r_s1 <= {sec_tens, sec_ones, tenths};
            r_s2 <= r_s1;
            if (w_frame_start && (r_s2 == r_s1) && !hold)
                r_shadow <= r_s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_slot <= 2'd0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_slot <= r_slot + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        case (r_slot)
            2'd0:    w_digit = r_shadow[3:0];
            2'd1:    w_digit = r_shadow[7:4];
            default: w_digit = r_shadow[11:8];
        endcase
    end

    // Slot 3 stays dark so each real digit keeps a quarter of the frame.
    assign w_gap  = (32'(r_cnt) < BLANK_CYCLES);
    assign w_dark = w_gap || (r_slot == 2'd3)
                 || ((r_slot == 2'd2) && (r_shadow[11:8] == 4'd0));

    always_comb begin
        w_an_nxt  = 4'hF;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (!w_dark) begin
            w_an_nxt  = ~(4'b0001 << r_slot);
            w_seg_nxt = f_decode(w_digit);
            w_dp_nxt  = (r_slot != 2'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed bench for stopwatch_display_scan with an 8-cycle slot and 2-cycle blanking gap.
// pos counts the scan position whose state the visible outputs reflect.
module tb_stopwatch_display_scan;

    logic       clk;
    logic       reset;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
    logic       hold;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int pos = -1;

    stopwatch_display_scan #(
        .DIGIT_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .tenths(tenths),
        .hold(hold),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [0:9];
        tab[0] = 7'b1000000; tab[1] = 7'b1111001;
        tab[2] = 7'b0100100; tab[3] = 7'b0110000;
        tab[4] = 7'b0011001; tab[5] = 7'b0010010;
        tab[6] = 7'b0000010; tab[7] = 7'b1111000;
        tab[8] = 7'b0000000; tab[9] = 7'b0010000;
        if (d > 4'd9) return 7'b0111111;
        return tab[d];
    endfunction

    function automatic logic [11:0] expect_out(input int p,
        input logic [3:0] t, input logic [3:0] o, input logic [3:0] d);
        int c;
        int s;
        c = p % 8;
        s = (p / 8) % 4;
        if (c < 2 || s == 3) return {4'hF, 7'h7F, 1'b1};
        if (s == 0) return {4'b1110, seg_of(d), 1'b1};
        if (s == 1) return {4'b1101, seg_of(o), 1'b0};
        if (t == 4'd0) return {4'hF, 7'h7F, 1'b1};
        return {4'b1011, seg_of(t), 1'b1};
    endfunction

    task automatic check(input string tag, input logic [11:0] exp);
        checks++;
        assert ({an, seg, dp} === exp) else begin
            errors++;
            $error("FAIL %s pos=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                   tag, pos, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        pos++;
        @(negedge clk);
    endtask

    task automatic span(input string tag, input int n, input logic tog,
        input logic [3:0] t, input logic [3:0] o, input logic [3:0] d);
        for (int i = 0; i < n; i++) begin
            if (tog) tenths = tenths ^ 4'h8;
            tick();
            check(tag, expect_out(pos, t, o, d));
        end
    endtask

    task automatic set_in(input logic [3:0] t, input logic [3:0] o, input logic [3:0] d);
        sec_tens = t;
        sec_ones = o;
        tenths   = d;
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        set_in(4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        check("reset_state", {4'hF, 7'h7F, 1'b1});
        reset = 1'b0;
        pos = -1;

        repeat (11) tick();
        check("pre_reset_slot1", {4'b1101, 7'b1000000, 1'b0});
        set_in(4'd1, 4'd2, 4'd3);
        #2 reset = 1'b1;
        #1 check("async_reset", {4'hF, 7'h7F, 1'b1});
        @(negedge clk);
        reset = 1'b0;
        pos = -1;

        span("frame0_reset_shadow", 32, 1'b0, 4'd0, 4'd0, 4'd0);
        span("frame1_123", 16, 1'b0, 4'd1, 4'd2, 4'd3);
        set_in(4'd0, 4'd5, 4'd0);
        span("frame1_no_tear", 16, 1'b0, 4'd1, 4'd2, 4'd3);
        check("frame1_slot3_end", {4'hF, 7'h7F, 1'b1});
        span("frame2_050", 16, 1'b0, 4'd0, 4'd5, 4'd0);
        set_in(4'd0, 4'd5, 4'hC);
        span("frame2_050_tail", 16, 1'b0, 4'd0, 4'd5, 4'd0);
        span("frame3_dash", 3, 1'b0, 4'd0, 4'd5, 4'hC);
        check("dash_hand", {4'b1110, 7'b0111111, 1'b1});
        span("frame3_dash_rest", 13, 1'b0, 4'd0, 4'd5, 4'hC);
        set_in(4'd0, 4'd0, 4'd7);
        span("frame3_tail", 16, 1'b0, 4'd0, 4'd5, 4'hC);
        span("frame4_007", 16, 1'b0, 4'd0, 4'd0, 4'd7);
        set_in(4'd0, 4'd0, 4'd8);
        span("frame4_still7", 16, 1'b0, 4'd0, 4'd0, 4'd7);
        span("frame5_008", 24, 1'b0, 4'd0, 4'd0, 4'd8);

        tenths = 4'd1;
        span("frame5_toggle", 8, 1'b1, 4'd0, 4'd0, 4'd8);
        span("frame6_toggle", 8, 1'b1, 4'd0, 4'd0, 4'd8);
        set_in(4'd0, 4'd1, 4'd1);
        span("frame6_kept", 24, 1'b0, 4'd0, 4'd0, 4'd8);
        span("frame7_011", 16, 1'b0, 4'd0, 4'd1, 4'd1);

        hold = 1'b1;
        set_in(4'd2, 4'd3, 4'd4);
        span("frame7_tail", 16, 1'b0, 4'd0, 4'd1, 4'd1);
        span("frame8_hold", 32, 1'b0, 4'd0, 4'd1, 4'd1);
        span("frame9_hold", 16, 1'b0, 4'd0, 4'd1, 4'd1);
        hold = 1'b0;
        span("frame9_release", 16, 1'b0, 4'd0, 4'd1, 4'd1);
        span("frame10_234", 19, 1'b0, 4'd2, 4'd3, 4'd4);
        check("tens_hand", {4'b1011, 7'b0100100, 1'b1});
        span("frame10_rest", 13, 1'b0, 4'd2, 4'd3, 4'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
